// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the fetch port, data port and memory bus of mem_arbiter.
// Latency : none here; this is wiring only.
// Backpr. : requesters hold req until ack; the memory holds off by delaying mem_ack.
// Ports   : slave = arbiter view (takes requests, drives the memory bus);
//           master = pipeline + memory view (drives requests, answers the bus).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_sel;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // memory bus
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // pipeline control
  logic [5:0]        stall;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           mem_sel, stall, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           mem_sel, stall, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port memory bus between the fetch and data ports.
// Latency : req -> mem_ce 1 cycle; mem_ack -> port ack/rdata 1 cycle; 3 cycles/access minimum.
// Backpr. : one access in flight; losing/waiting port is stalled via the stall vector.
// Ports   : clk, rst (sync, active-high); bus (mem_arbiter_if.slave) carrying
//           if_* fetch port, d_* data port, mem_* memory bus, stall and bus_err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int D_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, DONE} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic              d_grant;
  logic [5:0]        stall;

  // Data port takes the bus if it asks and either has priority or fetch is idle.
  assign d_grant = bus.d_req && ((D_FIRST != 0) || !bus.if_req);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_grant) begin
          state_d     = D_ACC;
          cnt_d       = 8'd1;
          mem_ce_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_sel_d   = bus.d_sel;
        end else if (bus.if_req) begin
          state_d     = IF_ACC;
          cnt_d       = 8'd1;
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_sel_d   = 4'hF;
        end
      end
      IF_ACC, D_ACC: begin
        // cnt_q is the number of the current cycle with mem_ce high, so the
        // abort fires after exactly TIMEOUT cycles of mem_ce.
        if (bus.mem_ack) begin
          state_d  = DONE;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == IF_ACC) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end
        end else if (cnt_q == TO_CNT) begin
          state_d   = DONE;
          mem_ce_d  = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == IF_ACC) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= 4'h0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Stall uses the registered acks so a port is released in its ack cycle;
  // a pending data access stalls further back than a fetch and wins.
  always_comb begin
    stall = 6'b000000;
    if (bus.d_req && !d_ack_q) begin
      stall = 6'b011111;
    end else if (bus.if_req && !if_ack_q) begin
      stall = 6'b000111;
    end
  end

  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall     = stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter.
// Latency : checks are taken 1 time unit after each rising edge.
// Backpr. : bench plays both requesters and the memory, driving mem_ack by hand.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  // bus_a: data-first, short timeout; bus_b: fetch-first
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .D_FIRST(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .D_FIRST(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_sel = '0;
    bus_a.mem_rdata = '0; bus_a.mem_ack = 0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_sel = '0;
    bus_b.mem_rdata = '0; bus_b.mem_ack = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_ce",     32'(bus_a.mem_ce),  0);
    chk("rst_addr",   bus_a.mem_addr,     0);
    chk("rst_sel",    32'(bus_a.mem_sel), 0);
    chk("rst_acks",   32'({bus_a.if_ack, bus_a.d_ack, bus_a.bus_err}), 0);
    chk("rst_stall",  32'(bus_a.stall),   0);
    chk("rst_b_ce",   32'(bus_b.mem_ce),  0);

    // 1: fetch, ack two cycles after mem_ce
    bus_a.if_addr = 32'h0000_0100; bus_a.if_req = 1;
    #1 chk("t1_stall_req", 32'(bus_a.stall), 32'b000111);
    step();
    chk("t1_ce",    32'(bus_a.mem_ce),  1);
    chk("t1_we",    32'(bus_a.mem_we),  0);
    chk("t1_sel",   32'(bus_a.mem_sel), 32'hF);
    chk("t1_addr",  bus_a.mem_addr,     32'h100);
    chk("t1_wdata", bus_a.mem_wdata,    0);
    step();
    chk("t1_wait_ce",    32'(bus_a.mem_ce), 1);
    chk("t1_wait_noack", 32'(bus_a.if_ack), 0);
    chk("t1_wait_stall", 32'(bus_a.stall),  32'b000111);
    step();
    bus_a.mem_rdata = 32'h3C01_0101; bus_a.mem_ack = 1;
    step();
    chk("t1_ack",       32'(bus_a.if_ack), 1);
    chk("t1_rdata",     bus_a.if_rdata,    32'h3C01_0101);
    chk("t1_ce_drop",   32'(bus_a.mem_ce), 0);
    chk("t1_stall_ack", 32'(bus_a.stall),  0);
    bus_a.mem_ack = 0; bus_a.if_req = 0;
    step();
    chk("t1_ack_pulse", 32'(bus_a.if_ack), 0);

    // 2: simultaneous requests, data first
    bus_a.if_addr = 32'h0000_0200; bus_a.if_req = 1;
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h0000_0300;
    bus_a.d_wdata = 32'hDEAD_BEEF; bus_a.d_sel = 4'b0011;
    #1 chk("t2_stall_both", 32'(bus_a.stall), 32'b011111);
    step();
    chk("t2_d_addr",  bus_a.mem_addr,     32'h300);
    chk("t2_d_we",    32'(bus_a.mem_we),  1);
    chk("t2_d_wdata", bus_a.mem_wdata,    32'hDEAD_BEEF);
    chk("t2_d_sel",   32'(bus_a.mem_sel), 32'b0011);
    bus_a.mem_rdata = 32'h1234_5678; bus_a.mem_ack = 1;
    step();
    chk("t2_d_ack",    32'(bus_a.d_ack),  1);
    chk("t2_if_noack", 32'(bus_a.if_ack), 0);
    chk("t2_d_rdata",  bus_a.d_rdata,     0);
    chk("t2_we_drop",  32'(bus_a.mem_we), 0);
    chk("t2_stall_if", 32'(bus_a.stall),  32'b000111);
    bus_a.d_req = 0; bus_a.mem_ack = 0;
    step();
    chk("t2_idle_ce", 32'(bus_a.mem_ce), 0);
    step();
    chk("t2_if_ce",   32'(bus_a.mem_ce), 1);
    chk("t2_if_addr", bus_a.mem_addr,    32'h200);
    chk("t2_if_sel",  32'(bus_a.mem_sel), 32'hF);
    bus_a.mem_rdata = 32'hA5A5_0001; bus_a.mem_ack = 1;
    step();
    chk("t2_if_ack",   32'(bus_a.if_ack), 1);
    chk("t2_if_rdata", bus_a.if_rdata,    32'hA5A5_0001);
    bus_a.if_req = 0; bus_a.mem_ack = 0;
    step();

    // 3: simultaneous requests, fetch first
    bus_b.if_addr = 32'h0000_0200; bus_b.if_req = 1;
    bus_b.d_req = 1; bus_b.d_we = 1; bus_b.d_addr = 32'h0000_0300;
    bus_b.d_wdata = 32'hDEAD_BEEF; bus_b.d_sel = 4'b0011;
    #1 chk("t3_stall_both", 32'(bus_b.stall), 32'b011111);
    step();
    chk("t3_if_addr", bus_b.mem_addr,    32'h200);
    chk("t3_if_we",   32'(bus_b.mem_we), 0);
    bus_b.mem_rdata = 32'h0BAD_F00D; bus_b.mem_ack = 1;
    step();
    chk("t3_if_ack",   32'(bus_b.if_ack), 1);
    chk("t3_d_noack",  32'(bus_b.d_ack),  0);
    chk("t3_if_rdata", bus_b.if_rdata,    32'h0BAD_F00D);
    bus_b.if_req = 0; bus_b.mem_ack = 0;
    step();
    chk("t3_if_pulse", 32'(bus_b.if_ack), 0);
    step();
    chk("t3_d_ce",    32'(bus_b.mem_ce), 1);
    chk("t3_d_addr",  bus_b.mem_addr,    32'h300);
    chk("t3_d_wdata", bus_b.mem_wdata,   32'hDEAD_BEEF);
    bus_b.mem_ack = 1;
    step();
    chk("t3_d_ack",    32'(bus_b.d_ack),  1);
    chk("t3_if_quiet", 32'(bus_b.if_ack), 0);
    chk("t3_d_rdata",  bus_b.d_rdata,     0);
    bus_b.d_req = 0; bus_b.mem_ack = 0;
    step();
    chk("t3_d_pulse", 32'(bus_b.d_ack), 0);

    // 4: normal data read, then a timed-out read
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h0000_0404; bus_a.d_sel = 4'hF;
    step();
    chk("t4_rd_we", 32'(bus_a.mem_we), 0);
    bus_a.mem_rdata = 32'hCAFE_F00D; bus_a.mem_ack = 1;
    step();
    chk("t4_rd_rdata", bus_a.d_rdata,      32'hCAFE_F00D);
    chk("t4_rd_noerr", 32'(bus_a.bus_err), 0);
    bus_a.d_req = 0; bus_a.mem_ack = 0;
    step();
    bus_a.d_req = 1; bus_a.d_addr = 32'h0000_0400;
    step();
    n = 0;
    while (bus_a.mem_ce === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("t4_ce_cycles", 32'(n),             4);
    chk("t4_to_ack",    32'(bus_a.d_ack),   1);
    chk("t4_to_err",    32'(bus_a.bus_err), 1);
    chk("t4_to_rdata",  bus_a.d_rdata,      0);
    bus_a.d_req = 0;
    step();
    chk("t4_err_pulse", 32'(bus_a.bus_err), 0);
    chk("t4_ack_pulse", 32'(bus_a.d_ack),   0);

    // 5: reset during a data access
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h0000_0600;
    step();
    chk("t5_ce", 32'(bus_a.mem_ce), 1);
    step();
    rst = 1; bus_a.d_req = 0;
    step();
    chk("t5_rst_ce",    32'(bus_a.mem_ce), 0);
    chk("t5_rst_ack",   32'(bus_a.d_ack),  0);
    chk("t5_rst_stall", 32'(bus_a.stall),  0);
    chk("t5_rst_rdata", bus_a.if_rdata,    0);
    rst = 0;
    step();
    chk("t5_post_ack", 32'(bus_a.d_ack),  0);
    chk("t5_post_ce",  32'(bus_a.mem_ce), 0);
    bus_a.if_addr = 32'h0000_0500; bus_a.if_req = 1;
    step();
    chk("t5_f_addr", bus_a.mem_addr, 32'h500);
    bus_a.mem_rdata = 32'h1111_2222; bus_a.mem_ack = 1;
    step();
    chk("t5_f_ack",   32'(bus_a.if_ack), 1);
    chk("t5_f_rdata", bus_a.if_rdata,    32'h1111_2222);
    bus_a.if_req = 0; bus_a.mem_ack = 0;
    step(); step();

    // 6: zero-wait memory, mem_ack held high throughout, continuous fetch
    bus_a.if_addr = 32'h0000_0700; bus_a.if_req = 1;
    bus_a.mem_ack = 1; bus_a.mem_rdata = 32'hF000_0000;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t6_ack_%0d", k), 32'(bus_a.if_ack), 32'((k % 3) == 2));
      chk($sformatf("t6_ce_%0d", k),  32'(bus_a.mem_ce), 32'((k % 3) == 1));
      if ((k % 3) == 2)
        chk($sformatf("t6_rdata_%0d", k), bus_a.if_rdata, 32'hF000_0000 | 32'(k - 1));
      bus_a.mem_rdata = 32'hF000_0000 | 32'(k);
    end
    bus_a.if_req = 0; bus_a.mem_ack = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
